// File: rtl/cap_buffer_responder.sv
// ============================================================================
//  Module      : cap_buffer_responder
//  Description : Responder end of the CAF capture-buffer interface: sample RAM
//                with buffered write responses and a backpressured read port.
//                Optional macro CAP_BUF_RDW_BYPASS_EN selects write-first
//                forwarding on same-address read/write collisions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cap_buffer_responder #(
   parameter int length     = 2048,
   parameter int index_bits = 11,
   parameter int i_bits     = 12,
   parameter int q_bits     = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [index_bits-1:0]      m_axi_cap_waddr,
   input  logic [i_bits+q_bits-1:0]   m_axi_cap_wdata,
   input  logic                       m_axi_cap_wvalid,
   output logic                       s_axi_cap_wready,
   output logic                       s_axi_cap_bvalid,
   output logic                       s_axi_cap_bresp,
   input  logic                       m_axi_cap_bready,
   input  logic [index_bits-1:0]      m_axi_cap_raddr,
   input  logic                       m_axi_cap_rvalid,
   output logic                       s_axi_cap_rready,
   output logic                       s_axi_cap_rvalid,
   output logic [i_bits-1:0]          cap_i,
   output logic [q_bits-1:0]          cap_q,
   input  logic                       m_axi_cap_rready
);

   localparam int                    c_DATA_W = i_bits + q_bits;
   localparam logic [index_bits:0]   c_LENGTH = (index_bits + 1)'(length);

   logic [c_DATA_W-1:0] mem_q [0:length-1];

   logic                bvalid_q, bvalid_d;
   logic                bresp_q,  bresp_d;
   logic                rvalid_q, rvalid_d;
   logic [c_DATA_W-1:0] rdata_q,  rdata_d;

   logic                w_wr_fire;
   logic                w_wr_in_range;
   logic                w_rd_fire;
   logic                w_rd_in_range;
   logic [c_DATA_W-1:0] w_rd_word;

   // Both channels accept whenever their output slot is empty or draining this cycle.
   assign s_axi_cap_wready = !bvalid_q || m_axi_cap_bready;
   assign s_axi_cap_rready = !rvalid_q || m_axi_cap_rready;

   assign w_wr_fire     = m_axi_cap_wvalid && s_axi_cap_wready;
   assign w_rd_fire     = m_axi_cap_rvalid && s_axi_cap_rready;
   assign w_wr_in_range = ({1'b0, m_axi_cap_waddr} < c_LENGTH);
   assign w_rd_in_range = ({1'b0, m_axi_cap_raddr} < c_LENGTH);

   always_ff @(posedge clk) begin
      if (w_wr_fire && w_wr_in_range) begin
         mem_q[m_axi_cap_waddr] <= m_axi_cap_wdata;
      end
   end

   always_comb begin
      w_rd_word = '0;
      if (w_rd_in_range) begin
`ifdef CAP_BUF_RDW_BYPASS_EN
         if (w_wr_fire && w_wr_in_range && (m_axi_cap_waddr == m_axi_cap_raddr)) begin
            w_rd_word = m_axi_cap_wdata;
         end else begin
            w_rd_word = mem_q[m_axi_cap_raddr];
         end
`else
         w_rd_word = mem_q[m_axi_cap_raddr];
`endif
      end
   end

   always_comb begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;

      // A fresh accept re-arms the response in the same cycle the old one drains.
      if (w_wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = !w_wr_in_range;
      end else if (m_axi_cap_bready) begin
         bvalid_d = 1'b0;
      end

      if (w_rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = w_rd_word;
      end else if (m_axi_cap_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bvalid_q <= 1'b0;
         bresp_q  <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_axi_cap_bvalid = bvalid_q;
   assign s_axi_cap_bresp  = bresp_q;
   assign s_axi_cap_rvalid = rvalid_q;
   assign cap_i            = rdata_q[c_DATA_W-1:q_bits];
   assign cap_q            = rdata_q[q_bits-1:0];

endmodule

`default_nettype wire
